sha256_compress: RTL
====================

# sha256_compress

Iterative SHA-256 compression engine: consumes one 512-bit block as a stream of 64 expanded message words W[0..63], runs the 64 rounds one word per accepted cycle, and produces the updated 256-bit chaining value. It sits directly downstream of the message-schedule expander. It is the consumer of the big-sigma-0 result Σ0(a), which feeds T2 of every round. The Σ0/Σ1 functions and the round arithmetic are combinational from the working registers.

## Interface
- Parameters: none.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  begin a block; sampled only in IDLE.
- hash_in  in  256  chaining value H0..H7, H0 in [255:224]; sampled with start.
- w_valid  in  1  w_data holds the next message word.
- w_data  in  32  W[t], in order t = 0..63.
- w_ready  out  1  engine accepts a word this cycle.
- busy  out  1  engine not in IDLE.
- done  out  1  one-cycle pulse; hash_out is valid from this cycle.
- hash_out  out  256  result H'0..H'7, H'0 in [255:224]; held until the next done.

## Operation
- States are IDLE, ROUND and FINAL.
- **IDLE:**
  - On start=1: load H0..H7 and a..h from hash_in, set t=0, go to ROUND.
  - Otherwise stay in IDLE.
- **ROUND:**
  - w_ready=1 (combinational from state).
  - On each edge with w_valid&&w_ready, execute round t and increment t (6-bit).
  - Without w_valid, all registers hold; no timeout.
  - When the word with t=63 is accepted, go to FINAL.
- **Round t, all arithmetic mod 2^32:**
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W.
  - T2 = Σ0(a) + Maj(a,b,c).
  - Update: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
- **Functions:**
  - Σ0 = rotr2^rotr13^rotr22; Σ1 = rotr6^rotr11^rotr25.
  - Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).
  - K[0..63] is the FIPS 180-4 constant table, held in an internal case ROM indexed by t.
- **FINAL** (one cycle): hash_out ← {H0+a, …, H7+h}, done←1, go to IDLE.
- **Control outputs:**
  - done is registered and high for exactly one cycle.
  - busy = (state != IDLE).
- **start rules:**
  - start while busy=1 is ignored and has no side effect.
  - start in the done cycle is legal, because the state is IDLE then.
- No padding and no schedule expansion inside this block; the upstream stage supplies all 64 W words.

## Timing
- Reset values:
  - state=IDLE; t=0; a..h=0; H0..H7=0.
  - hash_out=0; done=0; busy=0; w_ready=0.
- rst_n low at any time, including mid-block, aborts immediately. Any partial result is discarded; there is no done and hash_out goes to 0.
- Latency with w_valid held high:
  - start is sampled at edge E0.
  - Words are accepted at E1..E64.
  - FINAL edge is E65; done is high in the cycle after E65.
  - start-to-done is therefore 65 cycles.
- Each cycle of w_valid=0 during ROUND adds one cycle of latency.
- Throughput: one block per 66 cycles back-to-back (start asserted in the done cycle).

## Test plan
- **"abc", continuous w_valid:**
  - Stimulus: hash_in = IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19. Block W0=61626380, W1..W14=0, W15=00000018; W16..63 from the bench model.
  - Required: hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, done exactly 65 cycles after start.
- **Empty message, random w_valid gaps (about 30% idle):**
  - Stimulus: IV, W0=80000000, rest 0.
  - Required: hash e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855. Latency is 65 plus the number of gap cycles; no word is dropped or duplicated.
- **Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":**
  - Stimulus: second start in the done cycle, hash_in = first hash_out.
  - Required: final hash 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- **start pulsed at round 10 and at round 63:**
  - Required: ignored; the "abc" result is unchanged and done pulses once.
- **rst_n low for 1 cycle at round 30:**
  - Required: all outputs 0 and w_ready=0 immediately, no done. A following "abc" run then gives the correct hash.
- **w_valid high in IDLE and FINAL:**
  - Required: w_ready=0 and no words consumed; the following run gives the correct hash.

Source files
------------

// File: rtl/sha256_compress.sv
// sha256_compress
//   Iterative SHA-256 compression engine. Takes one 512-bit block as a stream of
//   64 pre-expanded message words W[0..63] and runs one round per accepted word,
//   then adds the working variables back into the chaining value.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             begin a block (sampled only in IDLE)
//   hash_in[255:0]    chaining value H0..H7, H0 in [255:224], sampled with start
//   w_valid, w_data   next message word W[t], t = 0..63 in order
//   w_ready           engine accepts a word this cycle (ROUND only)
//   busy              engine not in IDLE
//   done              one-cycle pulse, hash_out valid from this cycle
//   hash_out[255:0]   result H'0..H'7, H'0 in [255:224], held until next done
//   dbg_state[1:0]    current FSM state (0 IDLE, 1 ROUND, 2 FINAL)
//
// Handshake: a word transfers on a rising edge where w_valid && w_ready are both
// high. w_ready depends only on the state, never on w_valid, and the producer
// must hold w_data stable while w_valid is high and w_ready is low.
module sha256_compress (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] hash_in,
  input  logic         w_valid,
  input  logic [31:0]  w_data,
  output logic         w_ready,
  output logic         busy,
  output logic         done,
  output logic [255:0] hash_out,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [5:0]     t_q, t_d;
  logic [31:0]    a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  logic [31:0]    a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d;
  logic [255:0]   hv_q, hv_d;       // chaining value captured at start
  logic [255:0]   hash_q, hash_d;
  logic           done_q, done_d;

  // Round constant ROM, FIPS 180-4 K[0..63].
  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    case (idx)
      6'd0:  k_rom = 32'h428a2f98;  6'd1:  k_rom = 32'h71374491;
      6'd2:  k_rom = 32'hb5c0fbcf;  6'd3:  k_rom = 32'he9b5dba5;
      6'd4:  k_rom = 32'h3956c25b;  6'd5:  k_rom = 32'h59f111f1;
      6'd6:  k_rom = 32'h923f82a4;  6'd7:  k_rom = 32'hab1c5ed5;
      6'd8:  k_rom = 32'hd807aa98;  6'd9:  k_rom = 32'h12835b01;
      6'd10: k_rom = 32'h243185be;  6'd11: k_rom = 32'h550c7dc3;
      6'd12: k_rom = 32'h72be5d74;  6'd13: k_rom = 32'h80deb1fe;
      6'd14: k_rom = 32'h9bdc06a7;  6'd15: k_rom = 32'hc19bf174;
      6'd16: k_rom = 32'he49b69c1;  6'd17: k_rom = 32'hefbe4786;
      6'd18: k_rom = 32'h0fc19dc6;  6'd19: k_rom = 32'h240ca1cc;
      6'd20: k_rom = 32'h2de92c6f;  6'd21: k_rom = 32'h4a7484aa;
      6'd22: k_rom = 32'h5cb0a9dc;  6'd23: k_rom = 32'h76f988da;
      6'd24: k_rom = 32'h983e5152;  6'd25: k_rom = 32'ha831c66d;
      6'd26: k_rom = 32'hb00327c8;  6'd27: k_rom = 32'hbf597fc7;
      6'd28: k_rom = 32'hc6e00bf3;  6'd29: k_rom = 32'hd5a79147;
      6'd30: k_rom = 32'h06ca6351;  6'd31: k_rom = 32'h14292967;
      6'd32: k_rom = 32'h27b70a85;  6'd33: k_rom = 32'h2e1b2138;
      6'd34: k_rom = 32'h4d2c6dfc;  6'd35: k_rom = 32'h53380d13;
      6'd36: k_rom = 32'h650a7354;  6'd37: k_rom = 32'h766a0abb;
      6'd38: k_rom = 32'h81c2c92e;  6'd39: k_rom = 32'h92722c85;
      6'd40: k_rom = 32'ha2bfe8a1;  6'd41: k_rom = 32'ha81a664b;
      6'd42: k_rom = 32'hc24b8b70;  6'd43: k_rom = 32'hc76c51a3;
      6'd44: k_rom = 32'hd192e819;  6'd45: k_rom = 32'hd6990624;
      6'd46: k_rom = 32'hf40e3585;  6'd47: k_rom = 32'h106aa070;
      6'd48: k_rom = 32'h19a4c116;  6'd49: k_rom = 32'h1e376c08;
      6'd50: k_rom = 32'h2748774c;  6'd51: k_rom = 32'h34b0bcb5;
      6'd52: k_rom = 32'h391c0cb3;  6'd53: k_rom = 32'h4ed8aa4a;
      6'd54: k_rom = 32'h5b9cca4f;  6'd55: k_rom = 32'h682e6ff3;
      6'd56: k_rom = 32'h748f82ee;  6'd57: k_rom = 32'h78a5636f;
      6'd58: k_rom = 32'h84c87814;  6'd59: k_rom = 32'h8cc70208;
      6'd60: k_rom = 32'h90befffa;  6'd61: k_rom = 32'ha4506ceb;
      6'd62: k_rom = 32'hbef9a3f7;  6'd63: k_rom = 32'hc67178f2;
    endcase
  endfunction

  // Round datapath, purely combinational from the working registers.
  logic [31:0] big_sig0, big_sig1, ch, maj, k_t, t1, t2;

  assign big_sig0 = {a_q[1:0],  a_q[31:2]}  ^ {a_q[12:0], a_q[31:13]} ^ {a_q[21:0], a_q[31:22]};
  assign big_sig1 = {e_q[5:0],  e_q[31:6]}  ^ {e_q[10:0], e_q[31:11]} ^ {e_q[24:0], e_q[31:25]};
  assign ch       = (e_q & f_q) ^ (~e_q & g_q);
  assign maj      = (a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q);
  assign k_t      = k_rom(t_q);
  assign t1       = h_q + big_sig1 + ch + k_t + w_data;
  assign t2       = big_sig0 + maj;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q;
    e_d = e_q; f_d = f_q; g_d = g_q; h_d = h_q;
    hv_d    = hv_q;
    hash_d  = hash_q;
    done_d  = 1'b0;
    w_ready = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          hv_d = hash_in;
          {a_d, b_d, c_d, d_d, e_d, f_d, g_d, h_d} = hash_in;
          t_d     = 6'd0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        w_ready = 1'b1;
        if (w_valid) begin
          h_d = g_q;
          g_d = f_q;
          f_d = e_q;
          e_d = d_q + t1;
          d_d = c_q;
          c_d = b_q;
          b_d = a_q;
          a_d = t1 + t2;
          t_d = t_q + 6'd1;   // wraps back to 0 after round 63
          if (t_q == 6'd63) state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        hash_d = {hv_q[255:224] + a_q, hv_q[223:192] + b_q,
                  hv_q[191:160] + c_q, hv_q[159:128] + d_q,
                  hv_q[127:96]  + e_q, hv_q[95:64]   + f_q,
                  hv_q[63:32]   + g_q, hv_q[31:0]    + h_q};
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      t_q     <= 6'd0;
      a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
      e_q <= '0; f_q <= '0; g_q <= '0; h_q <= '0;
      hv_q    <= '0;
      hash_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
      e_q <= e_d; f_q <= f_d; g_q <= g_d; h_q <= h_d;
      hv_q    <= hv_d;
      hash_q  <= hash_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign hash_out  = hash_q;
  assign dbg_state = state_q;

endmodule
